// File: rtl/user_bus_burst_sram.sv
// Purpose : burst SRAM target for the user bus (write/read address bursts, byte-enabled writes).
// Latency : write beat commits in its handshake cycle; first read beat 2 cycles after the ar handshake.
// Backpr. : wready only in WRITE; reads stall on rready via a 2-entry output FIFO, 1 beat/cycle when open.
//
// Ports   : ACLK/ARESET (async, active-high); aw*/w* write address + data channels;
//           ar*/r* read address + data channels; err_wlast sticky wlast protocol error.
// Option  : define USER_BUS_SRAM_WLAST_CHECK_EN to build the err_wlast port and checker.
module user_bus_burst_sram #(
    parameter int C_ADDR_WIDTH   = 32,
    parameter int C_DATA_WIDTH   = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [C_ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [C_DATA_WIDTH-1:0]   rdata,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
    ,
    output logic                      err_wlast
`endif
);

    localparam int NB    = C_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                    state, state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] addr;     // shared burst word pointer (never read and write at once)
    logic [8:0]                cnt;      // beats still to write / reads still to issue
    logic [C_DATA_WIDTH-1:0]   mem [DEPTH];

    // SRAM read stage (one read in flight at most per cycle)
    logic [C_DATA_WIDTH-1:0]   rd_dat;
    logic                      rd_vld;
    logic                      rd_last;

    // Second FIFO slot; the first slot is the rdata/rlast/rvalid output register itself.
    logic [C_DATA_WIDTH-1:0]   tl_dat;
    logic                      tl_last;
    logic                      tl_vld;

    logic aw_hs, ar_hs, w_beat, issue, pop;
    logic [1:0] room_used;

    always_comb begin
        aw_hs  = (state == IDLE) & awvalid & awready;
        // Both readies are high in IDLE; a pending write wins and the read waits its turn.
        ar_hs  = (state == IDLE) & ~awvalid & arvalid & arready;
        w_beat = (state == WRITE) & wvalid & wready;
        pop    = rvalid & rready;
        // Occupancy after this cycle's pop plus the read in flight; counting the pop
        // keeps a full-rate stream going while still never overfilling the two slots.
        room_used = {1'b0, rvalid & ~rready} + {1'b0, tl_vld} + {1'b0, rd_vld};
        issue  = (state == READ) & (cnt != 9'd0) & (room_used < 2'd2);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (awvalid && awready)      state_nxt = WRITE;
                else if (arvalid && arready) state_nxt = READ;
            end
            WRITE:   if (w_beat && cnt == 9'd1) state_nxt = IDLE;
            READ:    if (pop && rlast)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= IDLE;
            awready <= 1'b0;
            arready <= 1'b0;
            wready  <= 1'b0;
            addr    <= '0;
            cnt     <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            state   <= state_nxt;
            awready <= (state_nxt == IDLE);
            arready <= (state_nxt == IDLE);
            wready  <= (state_nxt == WRITE);
            if (aw_hs) begin
                addr <= awaddr[SHIFT +: MEM_ADDR_WIDTH];
                cnt  <= {1'b0, awlen} + 9'd1;
            end else if (ar_hs) begin
                addr <= araddr[SHIFT +: MEM_ADDR_WIDTH];
                cnt  <= {1'b0, arlen} + 9'd1;
            end else if (w_beat || issue) begin
                addr <= addr + 1'b1;   // wraps naturally at the top of the array
                cnt  <= cnt - 9'd1;
            end
            rd_vld  <= issue;
            rd_last <= issue & (cnt == 9'd1);
        end
    end

    // Storage array; no reset. Writes are gated by wready, which reset clears at once.
    always_ff @(posedge ACLK) begin
        if (w_beat) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (issue) rd_dat <= mem[addr];
    end

    // Output FIFO: head register holds while stalled, tail slot absorbs the in-flight read.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            tl_vld  <= 1'b0;
            tl_last <= 1'b0;
            tl_dat  <= '0;
        end else if (pop && tl_vld) begin
            rvalid  <= 1'b1;
            rlast   <= tl_last;
            rdata   <= tl_dat;
            tl_vld  <= rd_vld;
            tl_last <= rd_last;
            tl_dat  <= rd_dat;
        end else if (pop || !rvalid) begin
            rvalid <= rd_vld;
            rlast  <= rd_last;
            if (rd_vld) rdata <= rd_dat;
        end else if (rd_vld) begin
            tl_vld  <= 1'b1;
            tl_last <= rd_last;
            tl_dat  <= rd_dat;
        end
    end

`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
    // Sticky: wlast must be high on exactly the beat that empties the count.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                                   err_wlast <= 1'b0;
        else if (w_beat && (wlast != (cnt == 9'd1))) err_wlast <= 1'b1;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, awaddr, araddr};
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, awaddr, araddr, wlast};
`endif

endmodule

// File: tb/tb_user_bus_burst_sram.sv
`timescale 1ns/1ps
module tb_user_bus_burst_sram;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        arvalid, arready, rlast, rvalid, rready;
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
    logic        err_wlast;
    logic        err_hist [256];
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aw_cyc, wl_cyc, ar_cyc, rx_first, rx_n, stall_err;

    logic [31:0] wr_dat  [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] rx_dat  [257];
    logic        rx_last [257];

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    user_bus_burst_sram dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
        , .err_wlast(err_wlast)
`endif
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input int bad_last);
        int budget;
        int i;
        awaddr = addr; awlen = len; awvalid = 1'b1;
        budget = 0;
        while (!awready && budget < 50) begin step(); budget++; end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready stayed %b, required 1", awready);
            awvalid = 1'b0;
            return;
        end
        step();
        aw_cyc = cyc;
        awvalid = 1'b0;
        i = 0; budget = 0;
        while (i <= int'(len) && budget < 1000) begin
            wdata = wr_dat[i]; wstrb = wr_strb[i]; wvalid = 1'b1;
            wlast = ((i == int'(len)) != (i == bad_last));
            if (wready) begin
                step();
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
                err_hist[i] = err_wlast;
`endif
                i++;
            end else begin
                step();
            end
            budget++;
        end
        wl_cyc = cyc;
        wvalid = 1'b0; wlast = 1'b0;
        if (i <= int'(len)) begin
            checks++; errors++;
            $display("FAIL w_timeout: beats done %0d, required %0d", i, int'(len) + 1);
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit rnd);
        int budget;
        logic prev_stall;
        logic [31:0] prev_dat;
        logic prev_last;
        araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
        budget = 0;
        while (!arready && budget < 50) begin step(); budget++; end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready stayed %b, required 1", arready);
            arvalid = 1'b0;
            return;
        end
        step();
        ar_cyc = cyc;
        arvalid = 1'b0;
        rx_n = 0; rx_first = -1; stall_err = 0; prev_stall = 1'b0;
        prev_dat = '0; prev_last = 1'b0;
        budget = 0;
        while (rx_n <= int'(len) && budget < 3000) begin
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (!rvalid || rdata !== prev_dat || rlast !== prev_last)) stall_err++;
            if (rvalid && rx_first < 0) rx_first = cyc;
            if (rvalid && rready) begin
                rx_dat[rx_n] = rdata; rx_last[rx_n] = rlast; rx_n++;
            end
            prev_stall = rvalid && !rready; prev_dat = rdata; prev_last = rlast;
            step();
            budget++;
        end
        rready = 1'b0;
        if (rx_n <= int'(len)) begin
            checks++; errors++;
            $display("FAIL r_timeout: beats received %0d, required %0d", rx_n, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        wvalid = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        step(); step(); step();
        checks++;
        if ({awready, arready, wready, rvalid, rlast} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 00000", {awready, arready, wready, rvalid, rlast});
        end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
        checks++;
        if (err_wlast !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_wlast); end
`endif
        ARESET = 1'b0;
        step();
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: aw/ar ready got %b, required 11", {awready, arready});
        end
    endtask

    task automatic test_single();
        wr_dat[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        write_burst(32'h10, 8'd0, -1);
        checks++;
        if (wl_cyc - aw_cyc !== 1) begin errors++; $display("FAIL single_wlat: got %0d, required 1", wl_cyc - aw_cyc); end
        checks++;
        if ({awready, wready} !== 2'b10) begin
            errors++;
            $display("FAIL single_wdone: awready/wready got %b, required 10", {awready, wready});
        end
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
        checks++;
        if (err_wlast !== 1'b0) begin errors++; $display("FAIL single_err: got %b, required 0", err_wlast); end
`endif
        read_burst(32'h10, 8'd0, 1'b0);
        checks++;
        if (rx_dat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h, required deadbeef", rx_dat[0]); end
        checks++;
        if (rx_last[0] !== 1'b1) begin errors++; $display("FAIL single_rlast: got %b, required 1", rx_last[0]); end
        checks++;
        if (rx_first - ar_cyc !== 2) begin errors++; $display("FAIL single_rlat: got %0d, required 2", rx_first - ar_cyc); end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL single_ardone: got %b, required 1", arready); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        logic        exp_l [4];
        exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'h2222B3B4; exp_d[2] = 32'hC0C0C0C0; exp_d[3] = 32'hD0D0D0D0;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0; exp_l[3] = 1'b1;
        wr_dat[0] = 32'h11111111; wr_dat[1] = 32'h22222222; wr_dat[2] = 32'h33333333; wr_dat[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
        write_burst(32'hFF8, 8'd3, -1);
        wr_dat[0] = 32'hA0A0A0A0; wr_dat[1] = 32'hB1B2B3B4; wr_dat[2] = 32'hC0C0C0C0; wr_dat[3] = 32'hD0D0D0D0;
        wr_strb[1] = 4'h3;
        write_burst(32'hFF8, 8'd3, -1);
        read_burst(32'hFF8, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_dat[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h, required %h", i, rx_dat[i], exp_d[i]); end
            checks++;
            if (rx_last[i] !== exp_l[i]) begin errors++; $display("FAIL wrap_rlast[%0d]: got %b, required %b", i, rx_last[i], exp_l[i]); end
        end
        // Full rate: last beat handshakes at T+N+1's following edge, arready seen then.
        checks++;
        if (cyc - ar_cyc !== 6 || arready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_rate: cycles %0d arready %b, required 6 and 1", cyc - ar_cyc, arready);
        end
        // Word 0x000 on its own, via the wrapped byte address 0.
        read_burst(32'h0, 8'd0, 1'b0);
        checks++;
        if (rx_dat[0] !== 32'hC0C0C0C0) begin errors++; $display("FAIL wrap_word0: got %h, required c0c0c0c0", rx_dat[0]); end
    endtask

    task automatic test_backpressure();
        int nlast;
        for (int i = 0; i < 256; i++) begin wr_dat[i] = 32'h5A000000 | i; wr_strb[i] = 4'hF; end
        write_burst(32'h400, 8'd255, -1);
        checks++;
        if (wl_cyc - aw_cyc !== 256) begin errors++; $display("FAIL bp_wbeats: got %0d, required 256", wl_cyc - aw_cyc); end
        read_burst(32'h400, 8'd255, 1'b1);
        checks++;
        if (rx_n !== 256) begin errors++; $display("FAIL bp_count: got %0d, required 256", rx_n); end
        nlast = 0;
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_dat[i] !== (32'h5A000000 | i)) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h, required %h", i, rx_dat[i], 32'h5A000000 | i);
            end
            if (rx_last[i] === 1'b1) nlast++;
        end
        checks++;
        if (rx_last[255] !== 1'b1 || nlast !== 1) begin
            errors++;
            $display("FAIL bp_rlast: last beat %b count %0d, required 1 and 1", rx_last[255], nlast);
        end
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_err); end
    endtask

    task automatic test_simultaneous();
        wr_dat[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
        araddr = 32'h200; arlen = 8'd0; arvalid = 1'b1;
        write_burst(32'h200, 8'd0, -1);
        read_burst(32'h200, 8'd0, 1'b0);
        checks++;
        if (ar_cyc - wl_cyc !== 1) begin errors++; $display("FAIL simul_order: ar accepted %0d after write end, required 1", ar_cyc - wl_cyc); end
        checks++;
        if (rx_dat[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL simul_data: got %h, required cafef00d", rx_dat[0]); end
    endtask

    task automatic test_reset_mid();
        int budget;
        wr_dat[0] = 32'h01010101; wr_dat[1] = 32'h02020202; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        write_burst(32'h80, 8'd1, -1);
        awaddr = 32'h80; awlen = 8'd3; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        wdata = 32'hE1E1E1E1; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wdata = 32'hE2E2E2E2;
        #3 ARESET = 1'b1;
        #1;
        checks++;
        if ({awready, arready, wready} !== 3'b000) begin
            errors++;
            $display("FAIL midw_reset: ready bits got %b, required 000", {awready, arready, wready});
        end
        step(); step();
        wvalid = 1'b0;
        ARESET = 1'b0;
        step();
        read_burst(32'h80, 8'd1, 1'b0);
        checks++;
        if (rx_dat[0] !== 32'hE1E1E1E1) begin errors++; $display("FAIL midw_beat1: got %h, required e1e1e1e1", rx_dat[0]); end
        checks++;
        if (rx_dat[1] !== 32'h02020202) begin errors++; $display("FAIL midw_abort: got %h, required 02020202", rx_dat[1]); end
        // Abort a stalled read burst.
        araddr = 32'h80; arlen = 8'd3; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        budget = 0;
        while (!rvalid && budget < 10) begin step(); budget++; end
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL midr_valid: got %b, required 1", rvalid); end
        #3 ARESET = 1'b1;
        #1;
        checks++;
        if ({rvalid, rlast, rdata} !== 34'h0) begin
            errors++;
            $display("FAIL midr_reset: rvalid %b rlast %b rdata %h, required all 0", rvalid, rlast, rdata);
        end
        step();
        ARESET = 1'b0;
        step();
        checks++;
        if ({awready, arready, rvalid} !== 3'b110) begin
            errors++;
            $display("FAIL midr_release: got %b, required 110", {awready, arready, rvalid});
        end
    endtask

`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
    task automatic test_wlast();
        wr_dat[0] = 32'h70000000; wr_dat[1] = 32'h71111111; wr_dat[2] = 32'h72222222; wr_dat[3] = 32'h73333333;
        for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
        write_burst(32'hC00, 8'd3, 1);
        checks++;
        if (err_hist[0] !== 1'b0) begin errors++; $display("FAIL wlast_beat1: got %b, required 0", err_hist[0]); end
        checks++;
        if (err_hist[1] !== 1'b1) begin errors++; $display("FAIL wlast_beat2: got %b, required 1", err_hist[1]); end
        read_burst(32'hC00, 8'd3, 1'b0);
        checks++;
        if (rx_dat[3] !== 32'h73333333 || rx_dat[1] !== 32'h71111111) begin
            errors++;
            $display("FAIL wlast_data: got %h %h, required 71111111 73333333", rx_dat[1], rx_dat[3]);
        end
        checks++;
        if (err_wlast !== 1'b1) begin errors++; $display("FAIL wlast_hold: got %b, required 1", err_wlast); end
        #3 ARESET = 1'b1;
        #1;
        checks++;
        if (err_wlast !== 1'b0) begin errors++; $display("FAIL wlast_clear: got %b, required 0", err_wlast); end
        step();
        ARESET = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
`ifdef USER_BUS_SRAM_WLAST_CHECK_EN
        test_wlast();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
